fetch_pc_sequencer: RTL and testbench
=====================================

// Module: fetch_pc_sequencer
// PURPOSE
//  Front half of the fetch stage. Owns the program counter and requests 22-bit instruction words from instruction memory.
//  Registers each returned word with a valid flag and drives the demux select (sel_incr) into the fetch-stage demux.
//  Handles branch redirects and downstream stalls.
// PARAMETERS
//  INSTR_W   22  instruction word width
//  ADDR_W    10  PC / imem address width
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous active-low reset
//  imem_addr      out  ADDR_W   fetch address (= pc)
//  imem_req       out  1        fetch request
//  imem_ack       in   1        imem_rdata valid this cycle; ignored unless imem_req=1
//  imem_rdata     in   INSTR_W  instruction word
//  branch_taken   in   1        redirect pulse, one cycle
//  branch_target  in   ADDR_W   redirect address
//  stall          in   1        downstream cannot consume instr_out
//  instr_out      out  INSTR_W  fetched instruction (demux input)
//  instr_valid    out  1        instr_out holds an unconsumed instruction
//  sel_incr       out  1        demux control: 1 = word came from sequential PC+1, 0 = first fetch after reset or redirect
//  instr_pc       out  ADDR_W   address instr_out was fetched from
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, state=S_IDLE, instr_out=0, instr_valid=0, sel_incr=0, instr_pc=0, seq flag=0.
//   - Reset mid-request abandons the request; a late imem_ack is ignored because imem_req=0.
//  States:
//   - S_IDLE: imem_req=0; always goes to S_FETCH on the next edge. Sole purpose: one bubble after reset.
//   - S_FETCH: imem_req = !(instr_valid && stall), combinational; imem_addr=pc.
//   - S_HOLD: imem_req=0; output is occupied and stalled.
//  accept = imem_req && imem_ack && !branch_taken. On accept, registered:
//   - instr_out<=imem_rdata, instr_valid<=1, instr_pc<=pc, sel_incr<=seq
//   - pc<=pc+1, wrapping modulo 2^ADDR_W (all-ones -> 0); seq<=1
//   - Latency: ack in cycle N -> instr_valid=1 in cycle N+1. One word per cycle sustained while ack=1 and stall=0.
//  Consumption: instr_valid && !stall at an edge consumes the word; instr_valid<=0 unless an accept happens the same edge.
//  Stall: instr_valid=1 and stall=1 -> instr_out, instr_pc and sel_incr hold unchanged.
//   - In S_FETCH this also moves to S_HOLD.
//   - S_HOLD -> S_FETCH when stall=0; the word is consumed on that edge.
//  Redirect (branch_taken=1), in any state except S_IDLE, highest priority:
//   - pc<=branch_target, seq<=0, instr_valid<=0 (held word flushed), next state S_FETCH.
//   - An imem_ack in the same cycle is discarded and pc is not incremented.
//   - Held in S_IDLE; consumed next cycle.
//  Simultaneous stall and branch: branch wins; the flush ignores stall.
//  Back-to-back redirects: the last one wins; no words are delivered between them.
//  imem_addr may change while imem_req=1 only on redirect; memory treats it as a new request.
// TESTING
//  1. Reset release, imem_ack tied 1, stall=0, rdata=addr+0x100 -> addr 0,1,2,...; first word valid 2 cycles after release with sel_incr=0, later words sel_incr=1.
//  2. PC=0x3FF accepted -> next imem_addr=0x000; instr_pc of the 0x3FF word reads 0x3FF.
//  3. stall=1 for 3 cycles while valid -> instr_out stable, imem_req=0; stall drop -> the same word is consumed once, then fetching resumes at pc.
//  4. branch_taken with target 0x055 in the same cycle as ack -> that word is dropped, instr_valid=0 next cycle, next request at 0x055, delivered with sel_incr=0.
//  5. branch_taken during S_HOLD with stall=1 -> held word flushed (valid=0), fetch at target.
//  6. rst_n pulsed low mid-request with ack arriving after release -> outputs at reset values, fetch restarts at RESET_PC after the S_IDLE bubble.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC sequencer: owns the program counter, issues imem requests,
// registers returned words with a valid flag and the demux select, and
// handles branch redirects and downstream stalls.
module fetch_pc_sequencer #(
  parameter int INSTR_W  = 22,
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               sel_incr,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              seq;
  // A redirect seen during the reset bubble is parked and applied next cycle.
  logic              pend;
  logic [ADDR_W-1:0] pend_tgt;

  logic              br_live;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              accept;

  assign br_live      = branch_taken && (state != S_IDLE);
  assign redirect     = br_live || pend;
  // A live branch is younger than a parked one, so it wins.
  assign redirect_tgt = br_live ? branch_target : pend_tgt;
  assign accept       = imem_req && imem_ack && !redirect;
  assign imem_addr    = pc;

  // Request generation and next-state selection.
  always_comb begin
    imem_req  = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = !(instr_valid && stall);
        if (redirect)                  state_nxt = S_FETCH;
        else if (instr_valid && stall) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (redirect || !stall) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Park a redirect that arrives during the reset bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else begin
      pend <= (state == S_IDLE) && branch_taken;
      if ((state == S_IDLE) && branch_taken) pend_tgt <= branch_target;
    end
  end

  // PC and sequential flag: redirect loads target, accept advances by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RST_PC;
      seq <= 1'b0;
    end else if (redirect) begin
      pc  <= redirect_tgt;
      seq <= 1'b0;
    end else if (accept) begin
      pc  <= pc + ADDR_W'(1);
      seq <= 1'b1;
    end
  end

  // Output word register: flush on redirect, load on accept, clear on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out   <= '0;
      instr_valid <= 1'b0;
      sel_incr    <= 1'b0;
      instr_pc    <= '0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (accept) begin
      instr_out   <= imem_rdata;
      instr_valid <= 1'b1;
      instr_pc    <= pc;
      sel_incr    <= seq;
    end else if (instr_valid && !stall) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed, table-driven bench for fetch_pc_sequencer. Memory model returns
// addr + 0x100 for every address.
module tb_fetch_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [21:0] imem_rdata;
  logic        branch_taken;
  logic [9:0]  branch_target;
  logic        stall;
  logic [21:0] instr_out;
  logic        instr_valid;
  logic        sel_incr;
  logic [9:0]  instr_pc;

  int n_run  = 0;
  int n_fail = 0;

  fetch_pc_sequencer #(.INSTR_W(22), .ADDR_W(10), .RESET_PC(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .sel_incr     (sel_incr),
    .instr_pc     (instr_pc)
  );

  // Instruction memory model.
  assign imem_rdata = {12'd0, imem_addr} + 22'h100;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-cycle vector: inputs, then expected comb outputs before the edge and
  // registered outputs after it.
  typedef struct packed {
    logic        ack;
    logic        br;
    logic [9:0]  tgt;
    logic        stl;
    logic        req;
    logic [9:0]  addr;
    logic        vld;
    logic [21:0] ins;
    logic        sel;
    logic [9:0]  ipc;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic vec_t mk(logic ack, logic br, logic [9:0] tgt, logic stl,
                              logic req, logic [9:0] addr, logic vld,
                              logic [21:0] ins, logic sel, logic [9:0] ipc);
    vec_t v;
    v.ack = ack; v.br = br; v.tgt = tgt; v.stl = stl;
    v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.sel = sel; v.ipc = ipc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_pre(input string nm, input logic req, input logic [9:0] addr);
    chk({nm, " req"},  64'(imem_req),  64'(req));
    chk({nm, " addr"}, 64'(imem_addr), 64'(addr));
  endtask

  task automatic chk_post(input string nm, input logic vld, input logic [21:0] ins,
                          input logic sel, input logic [9:0] ipc);
    chk({nm, " out"}, {31'd0, instr_valid, instr_out, sel_incr, instr_pc},
                      {31'd0, vld, ins, sel, ipc});
  endtask

  initial begin
    // ack, br, tgt, stall | req, addr | valid, instr, sel, ipc
    vt[0]  = mk(1, 0, 0,      0, 0, 10'h000, 0, 22'h000, 0, 10'h000); // idle bubble
    vt[1]  = mk(1, 0, 0,      0, 1, 10'h000, 1, 22'h100, 0, 10'h000); // first word
    vt[2]  = mk(1, 0, 0,      0, 1, 10'h001, 1, 22'h101, 1, 10'h001);
    vt[3]  = mk(1, 0, 0,      0, 1, 10'h002, 1, 22'h102, 1, 10'h002);
    vt[4]  = mk(0, 0, 0,      0, 1, 10'h003, 0, 22'h102, 1, 10'h002); // no ack: consumed
    vt[5]  = mk(1, 0, 0,      1, 1, 10'h003, 1, 22'h103, 1, 10'h003); // stall w/o valid
    vt[6]  = mk(1, 0, 0,      1, 0, 10'h004, 1, 22'h103, 1, 10'h003); // stall 1
    vt[7]  = mk(1, 0, 0,      1, 0, 10'h004, 1, 22'h103, 1, 10'h003); // stall 2 (hold)
    vt[8]  = mk(1, 0, 0,      1, 0, 10'h004, 1, 22'h103, 1, 10'h003); // stall 3
    vt[9]  = mk(1, 0, 0,      0, 0, 10'h004, 0, 22'h103, 1, 10'h003); // consume once
    vt[10] = mk(1, 0, 0,      0, 1, 10'h004, 1, 22'h104, 1, 10'h004); // resume at pc
    vt[11] = mk(1, 1, 10'h055, 0, 1, 10'h005, 0, 22'h104, 1, 10'h004); // branch + ack
    vt[12] = mk(1, 0, 0,      0, 1, 10'h055, 1, 22'h155, 0, 10'h055);
    vt[13] = mk(1, 0, 0,      0, 1, 10'h056, 1, 22'h156, 1, 10'h056);
    vt[14] = mk(1, 0, 0,      1, 0, 10'h057, 1, 22'h156, 1, 10'h056); // into hold
    vt[15] = mk(0, 1, 10'h3FE, 1, 0, 10'h057, 0, 22'h156, 1, 10'h056); // branch in hold
    vt[16] = mk(1, 0, 0,      1, 1, 10'h3FE, 1, 22'h4FE, 0, 10'h3FE);
    vt[17] = mk(1, 0, 0,      0, 1, 10'h3FF, 1, 22'h4FF, 1, 10'h3FF); // top address
    vt[18] = mk(1, 0, 0,      0, 1, 10'h000, 1, 22'h100, 1, 10'h000); // wrapped
    vt[19] = mk(1, 1, 10'h200, 0, 1, 10'h001, 0, 22'h100, 1, 10'h000); // redirect 1
    vt[20] = mk(1, 1, 10'h300, 0, 1, 10'h200, 0, 22'h100, 1, 10'h000); // redirect 2
    vt[21] = mk(1, 0, 0,      0, 1, 10'h300, 1, 22'h400, 0, 10'h300); // last wins

    rst_n = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
    #3;
    chk_pre("reset", 1'b0, 10'h000);
    chk_post("reset", 1'b0, 22'h0, 1'b0, 10'h000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      imem_ack = vt[i].ack; branch_taken = vt[i].br;
      branch_target = vt[i].tgt; stall = vt[i].stl;
      #2;
      chk_pre($sformatf("vec%0d pre", i), vt[i].req, vt[i].addr);
      @(posedge clk); #1;
      chk_post($sformatf("vec%0d post", i), vt[i].vld, vt[i].ins, vt[i].sel, vt[i].ipc);
      @(negedge clk);
    end

    // Reset mid-request; ack stays high across release and must be ignored
    // during the bubble.
    imem_ack = 1'b1; branch_taken = 1'b0; stall = 1'b0;
    #2;
    chk_pre("midreq pre", 1'b1, 10'h301);
    rst_n = 1'b0;
    #1;
    chk_pre("async rst", 1'b0, 10'h000);
    chk_post("async rst", 1'b0, 22'h0, 1'b0, 10'h000);
    @(posedge clk); #1;
    chk_post("in rst", 1'b0, 22'h0, 1'b0, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk_pre("rst bubble", 1'b0, 10'h000);
    @(posedge clk); #1;
    chk_post("rst bubble", 1'b0, 22'h0, 1'b0, 10'h000);
    @(negedge clk); #2;
    chk_pre("rst refetch", 1'b1, 10'h000);
    @(posedge clk); #1;
    chk_post("rst refetch", 1'b1, 22'h100, 1'b0, 10'h000);
    @(negedge clk); #2;
    chk_pre("rst seq", 1'b1, 10'h001);
    @(posedge clk); #1;
    chk_post("rst seq", 1'b1, 22'h101, 1'b1, 10'h001);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
